// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg
// Shared definitions for the boot-time system ID check master.
//   state_t     : top-level sequencing states
//   ERR_*       : sticky result codes reported on err_code
//   ID_OFS/TS_OFS : byte offsets of the ID and timestamp words in the sysid slave
//   TIMER_W     : width of the per-read timeout counter
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [31:0] ID_OFS = 32'd0;
  localparam logic [31:0] TS_OFS = 32'd4;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/sysid_check_master_if.sv
// sysid_check_master_if
// Avalon-MM read-only bus between the check master and the sysid slave.
//   avm_address       : byte address (master -> slave)
//   avm_read          : read request (master -> slave)
//   avm_waitrequest   : slave stall (slave -> master)
//   avm_readdata      : read data (slave -> master)
//   avm_readdatavalid : read response strobe (slave -> master)
interface sysid_check_master_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/sysid_read_port.sv
// sysid_read_port
// Issues one Avalon-MM read per go pulse and reports its outcome.
//   clock, reset : clock and asynchronous active-high reset
//   i_go         : launch a read at i_addr (only pulsed while the port is idle)
//   i_addr       : byte address for the read
//   o_busy       : a read is outstanding (requesting or awaiting data)
//   o_accept     : the request was accepted this cycle
//   o_valid      : the response for the outstanding read arrived this cycle
//   o_timeout    : the read exceeded TIMEOUT_CYCLES and has been abandoned
//   o_rdata      : read data, meaningful with o_valid
//   avm          : Avalon-MM master side of the bus
module sysid_read_port
  import sysid_check_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_go,
  input  logic [31:0]           i_addr,
  output logic                  o_busy,
  output logic                  o_accept,
  output logic                  o_valid,
  output logic                  o_timeout,
  output logic [31:0]           o_rdata,
  sysid_check_master_if.master  avm
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  logic               r_read;
  logic               r_waiting;
  logic [31:0]        r_address;
  logic [TIMER_W-1:0] r_timer;

  logic w_accept;
  logic w_valid;
  logic w_timeout;

  // A response only counts while this port owns a read: either it is
  // awaiting data, or the request is being accepted right now (zero-latency
  // slave). Anything else on readdatavalid is a stray strobe and ignored.
  // The timer holds the 1-based cycle number of the current read, so a
  // timeout fires in the TIMEOUT_CYCLES-th cycle unless data shows up in
  // that same cycle, in which case the data wins.
  always_comb begin
    w_accept  = r_read & ~avm.avm_waitrequest;
    w_valid   = avm.avm_readdatavalid & (w_accept | r_waiting);
    w_timeout = (r_read | r_waiting) & ~w_valid & (r_timer == TIMEOUT_LIMIT);
  end

  // Request/response tracking. The request is registered so read and
  // address stay rock steady through waitrequest stalls. On timeout the
  // request is dropped outright to abort a bus that has stopped answering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_read    <= 1'b0;
      r_waiting <= 1'b0;
      r_address <= '0;
      r_timer   <= '0;
    end else if (i_go) begin
      r_read    <= 1'b1;
      r_waiting <= 1'b0;
      r_address <= i_addr;
      r_timer   <= TIMER_W'(1);
    end else if (r_read | r_waiting) begin
      if (w_valid | w_timeout) begin
        r_read    <= 1'b0;
        r_waiting <= 1'b0;
      end else if (w_accept) begin
        r_read    <= 1'b0;
        r_waiting <= 1'b1;
      end
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  assign avm.avm_read    = r_read;
  assign avm.avm_address = r_address;
  assign o_busy          = r_read | r_waiting;
  assign o_accept        = w_accept;
  assign o_valid         = w_valid;
  assign o_timeout       = w_timeout;
  assign o_rdata         = avm.avm_readdata;

endmodule

// File: rtl/sysid_check_master.sv
// sysid_check_master
// Boot-time identity check: reads the sysid ID word then the timestamp word
// and compares both against expected constants.
//   clock, reset : clock and asynchronous active-high reset
//   avm          : Avalon-MM read master toward the sysid slave
//   start        : pulse to begin a check (honoured only when idle)
//   busy         : a check is in progress
//   done         : one-cycle pulse when a check completes
//   pass         : sticky, both words matched
//   err_code     : sticky, ERR_NONE / ERR_ID / ERR_TS / ERR_TIMEOUT
//   id_value     : last captured ID word
//   ts_value     : last captured timestamp word
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490938479,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  sysid_check_master_if.master  avm,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            err_code,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_pass;
  logic [1:0]  r_errCode;
  logic [31:0] r_idValue;
  logic [31:0] r_tsValue;

  logic        w_go;
  logic [31:0] w_addr;
  logic        w_portBusy;
  logic        w_accept;
  logic        w_valid;
  logic        w_timeout;
  logic [31:0] w_rdata;
  logic        w_inId;
  logic        w_inTs;

  sysid_read_port #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_readPort (
    .clock     (clock),
    .reset     (reset),
    .i_go      (w_go),
    .i_addr    (w_addr),
    .o_busy    (w_portBusy),
    .o_accept  (w_accept),
    .o_valid   (w_valid),
    .o_timeout (w_timeout),
    .o_rdata   (w_rdata),
    .avm       (avm)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state sequencing of the two reads. A response always takes
  // precedence over a timeout, and an ID mismatch skips the timestamp read.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_nextState = REQ_ID;
      end
      REQ_ID, WAIT_ID: begin
        if (w_valid) w_nextState = (w_rdata == EXPECTED_ID) ? REQ_TS : FINISH;
        else if (w_timeout) w_nextState = FINISH;
        else if (w_accept) w_nextState = WAIT_ID;
      end
      REQ_TS, WAIT_TS: begin
        if (w_valid | w_timeout) w_nextState = FINISH;
        else if (w_accept) w_nextState = WAIT_TS;
      end
      FINISH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Outputs and read launches. The ID read launches straight from the start
  // pulse so the bus request appears the very next cycle. The timestamp read
  // launches from the first REQ_TS cycle, giving the port one idle cycle of
  // turnaround after the ID response before it drives the next request.
  always_comb begin
    busy   = (r_state != IDLE);
    done   = (r_state == FINISH);
    w_inId = (r_state == REQ_ID) || (r_state == WAIT_ID);
    w_inTs = (r_state == REQ_TS) || (r_state == WAIT_TS);
    w_go   = ((r_state == IDLE) && start) || ((r_state == REQ_TS) && !w_portBusy);
    w_addr = (r_state == REQ_TS) ? (BASE_ADDR + TS_OFS) : (BASE_ADDR + ID_OFS);
  end

  // Sticky results. They clear only when a new check is accepted; the
  // timestamp capture is left untouched when the ID word already failed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pass    <= 1'b0;
      r_errCode <= ERR_NONE;
      r_idValue <= '0;
      r_tsValue <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_pass    <= 1'b0;
      r_errCode <= ERR_NONE;
    end else if (w_inId && w_valid) begin
      r_idValue <= w_rdata;
      if (w_rdata != EXPECTED_ID) r_errCode <= ERR_ID;
    end else if (w_inTs && w_valid) begin
      r_tsValue <= w_rdata;
      if (w_rdata == EXPECTED_TS) r_pass <= 1'b1;
      else r_errCode <= ERR_TS;
    end else if ((w_inId || w_inTs) && w_timeout) begin
      r_errCode <= ERR_TIMEOUT;
    end
  end

  assign pass     = r_pass;
  assign err_code = r_errCode;
  assign id_value = r_idValue;
  assign ts_value = r_tsValue;

endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master
// Self-checking bench for sysid_check_master with a reactive Avalon slave
// model and a cycle-count reference model of a complete identity check.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1490938479;
  localparam int          TO     = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  errCode;
  logic [31:0] idValue;
  logic [31:0] tsValue;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelId = 32'd0;
  logic [31:0] modelTs = 32'd0;

  sysid_check_master_if avm ();

  sysid_check_master #(
    .BASE_ADDR      (32'h0000_0000),
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .avm      (avm),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_code (errCode),
    .id_value (idValue),
    .ts_value (tsValue)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Runs one full check against a slave that stalls each request for
  // 'stall' cycles and answers 'latency' cycles after acceptance (0 = same
  // cycle), or never answers when noResp is set. The expected outcome is
  // derived from the cost of one read (stall + 1 + latency cycles from read
  // assertion to data) and the fixed overheads: one cycle from start to the
  // first request, one turnaround cycle between reads, one finish cycle.
  task automatic applyStimulus(input string name, input logic [31:0] word0, input logic [31:0] word1,
                               input int stall, input int latency, input bit noResp, input bit extraStarts);
    int          doneCycle = -1;
    int          doneCount = 0;
    int          reads = 0;
    int          lastRead = -1;
    int          stallLeft = 0;
    int          countdown = 0;
    logic [31:0] addrs [2];
    logic [31:0] pendData = 32'd0;
    logic [31:0] prevAddr = 32'd0;
    logic        prevRead = 1'b0;
    logic        stableOk = 1'b1;
    logic        busyAfter = 1'b1;
    int          d;
    bit          idOk;
    int          expDone;
    int          expReads;
    int          expLastRead;
    int          readStart;
    logic        expPass = 1'b0;
    logic [1:0]  expErr = 2'd0;

    addrs[0] = 32'hDEAD_BEEF;
    addrs[1] = 32'hDEAD_BEEF;

    @(posedge clock); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clock); #1;
      start = extraStarts && (cyc == 1);
      avm.avm_waitrequest   = 1'b0;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = $urandom;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
        if (extraStarts) start = 1'b1;
      end
      if (avm.avm_read) begin
        lastRead = cyc;
        if (!prevRead) begin
          stallLeft = stall;
          if (reads < 2) addrs[reads] = avm.avm_address;
          reads++;
        end else if (avm.avm_address !== prevAddr) begin
          stableOk = 1'b0;
        end
        prevAddr = avm.avm_address;
        if (stallLeft > 0) begin
          avm.avm_waitrequest = 1'b1;
          stallLeft--;
        end else if (!noResp) begin
          pendData = (avm.avm_address == 32'h4) ? word1 : word0;
          if (latency == 0) begin
            avm.avm_readdatavalid = 1'b1;
            avm.avm_readdata      = pendData;
          end else begin
            countdown = latency;
          end
        end
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          avm.avm_readdatavalid = 1'b1;
          avm.avm_readdata      = pendData;
        end
      end
      prevRead = avm.avm_read;
      if ((doneCycle >= 0) && (cyc == doneCycle + 1)) begin
        busyAfter = busy;
        break;
      end
    end
    start                 = 1'b0;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdatavalid = 1'b0;

    d    = stall + 1 + latency;
    idOk = !noResp && (d <= TO);
    readStart = 1;
    if (!idOk) begin
      expDone  = 1 + TO;
      expReads = 1;
      expErr   = 2'd3;
    end else begin
      modelId = word0;
      if (word0 != EXP_ID) begin
        expDone  = d + 1;
        expReads = 1;
        expErr   = 2'd1;
      end else begin
        expReads  = 2;
        readStart = d + 2;
        if (d > TO) begin
          expDone = readStart + TO;
          expErr  = 2'd3;
        end else begin
          modelTs = word1;
          expDone = 2 * d + 2;
          expPass = (word1 == EXP_TS);
          expErr  = expPass ? 2'd0 : 2'd2;
        end
      end
    end
    expLastRead = readStart + ((stall >= TO) ? (TO - 1) : stall);

    checkOutput({name, ".doneCycle"}, 32'(doneCycle), 32'(expDone));
    checkOutput({name, ".doneCount"}, 32'(doneCount), 32'd1);
    checkOutput({name, ".pass"}, 32'(pass), 32'(expPass));
    checkOutput({name, ".errCode"}, 32'(errCode), 32'(expErr));
    checkOutput({name, ".idValue"}, idValue, modelId);
    checkOutput({name, ".tsValue"}, tsValue, modelTs);
    checkOutput({name, ".reads"}, 32'(reads), 32'(expReads));
    checkOutput({name, ".addrId"}, addrs[0], 32'h0);
    if (expReads == 2) checkOutput({name, ".addrTs"}, addrs[1], 32'h4);
    checkOutput({name, ".stable"}, 32'(stableOk), 32'd1);
    checkOutput({name, ".lastRead"}, 32'(lastRead), 32'(expLastRead));
    checkOutput({name, ".busyAfter"}, 32'(busyAfter), 32'd0);

    repeat (2) @(posedge clock);
  endtask

  // Checks every observable output against its reset value.
  task automatic checkResetState(input string name);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
    checkOutput({name, ".done"}, 32'(done), 32'd0);
    checkOutput({name, ".pass"}, 32'(pass), 32'd0);
    checkOutput({name, ".errCode"}, 32'(errCode), 32'd0);
    checkOutput({name, ".idValue"}, idValue, 32'd0);
    checkOutput({name, ".tsValue"}, tsValue, 32'd0);
    checkOutput({name, ".read"}, 32'(avm.avm_read), 32'd0);
    checkOutput({name, ".address"}, avm.avm_address, 32'd0);
  endtask

  // Resets the design while it awaits the timestamp word, then fires a
  // stray response that must be ignored.
  task automatic resetMidCheck();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    avm.avm_readdatavalid = 1'b1;
    avm.avm_readdata      = EXP_ID;
    @(posedge clock); #1;
    avm.avm_readdatavalid = 1'b0;
    @(posedge clock); #1;
    checkOutput("rst.tsRead", 32'(avm.avm_read), 32'd1);
    @(posedge clock); #1;
    checkOutput("rst.busyBefore", 32'(busy), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    avm.avm_readdatavalid = 1'b1;
    avm.avm_readdata      = EXP_TS;
    @(posedge clock); #1;
    avm.avm_readdatavalid = 1'b0;
    @(negedge clock);
    checkResetState("rst");
    modelId = 32'd0;
    modelTs = 32'd0;
    repeat (2) @(posedge clock);
  endtask

  // Test sequence: reset values, directed cases, reset recovery, random runs.
  initial begin
    reset                 = 1'b1;
    start                 = 1'b0;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata      = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetState("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    applyStimulus("zeroWait", EXP_ID, EXP_TS, 0, 1, 1'b0, 1'b0);
    applyStimulus("stall3", EXP_ID, EXP_TS, 3, 1, 1'b0, 1'b0);
    applyStimulus("idBad", 32'h0000_0001, EXP_TS, 0, 1, 1'b0, 1'b0);
    applyStimulus("tsBad", EXP_ID, 32'd1490938480, 0, 1, 1'b0, 1'b0);
    applyStimulus("stuckWait", EXP_ID, EXP_TS, 100, 0, 1'b0, 1'b0);
    applyStimulus("noResp", EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b0);
    applyStimulus("respAtLimit", EXP_ID, EXP_TS, 0, 7, 1'b0, 1'b0);
    applyStimulus("respPastLimit", EXP_ID, EXP_TS, 0, 8, 1'b0, 1'b0);
    applyStimulus("zeroLatency", EXP_ID, EXP_TS, 0, 0, 1'b0, 1'b1);
    resetMidCheck();
    applyStimulus("afterReset", EXP_ID, EXP_TS, 0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] w0;
      logic [31:0] w1;
      w0 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      w1 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      applyStimulus($sformatf("rand%0d", i), w0, w1, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0),
                    bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
